// File: rtl/comp_pkg.sv
// Shared types for the serial magnitude comparator: FSM state encoding and result flags.
package comp_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} comp_state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } comp_res_t;

endpackage

// File: rtl/comp_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice of each operand.
module comp_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             gt,
  output logic             lt
);

  assign gt = (x > y);
  assign lt = (x < y);

endmodule

// File: rtl/serial_mag_comp.sv
// Multi-cycle MSB-first magnitude comparator with early exit and start/busy/done handshake.
// Define COMP_SIGNED_EN to compare operands as two's complement instead of unsigned.
module serial_mag_comp
  import comp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             yg,
  output logic             yl,
  output logic             ye
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  comp_state_t      state, state_nxt;
  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-1:0] a_cap, b_cap;
  logic [CW-1:0]    cnt;
  comp_res_t        res, res_nxt;
  logic             load, shift;
  logic             dig_gt, dig_lt;

  comp_digit #(.DIGIT(DIGIT)) u_digit (
    .x  (sa[WIDTH-1 -: DIGIT]),
    .y  (sb[WIDTH-1 -: DIGIT]),
    .gt (dig_gt),
    .lt (dig_lt)
  );

  // Flipping both sign bits maps two's complement onto offset binary, so the
  // unsigned digit compare then yields signed order.
  always_comb begin
    a_cap = a;
    b_cap = b;
`ifdef COMP_SIGNED_EN
    a_cap[WIDTH-1] = ~a[WIDTH-1];
    b_cap[WIDTH-1] = ~b[WIDTH-1];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    res_nxt   = res;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (dig_gt) begin
          res_nxt   = '{gt: 1'b1, lt: 1'b0, eq: 1'b0};
          state_nxt = ST_DONE;
        end else if (dig_lt) begin
          res_nxt   = '{gt: 1'b0, lt: 1'b1, eq: 1'b0};
          state_nxt = ST_DONE;
        end else if (cnt == CW'(1)) begin
          res_nxt   = '{gt: 1'b0, lt: 1'b0, eq: 1'b1};
          state_nxt = ST_DONE;
        end else begin
          shift = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (load) res_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      cnt <= '0;
      res <= '0;
    end else begin
      res <= res_nxt;
      if (load) begin
        sa  <= a_cap;
        sb  <= b_cap;
        cnt <= CW'(N);
      end else if (shift) begin
        sa  <= sa << DIGIT;
        sb  <= sb << DIGIT;
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign yg   = res.gt;
  assign yl   = res.lt;
  assign ye   = res.eq;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Randomized and directed bench for serial_mag_comp against an arithmetic reference model.
module tb_serial_mag_comp;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;
  localparam int WAIT_MAX = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, yg, yl, ye;

  int total = 0;
  int bad   = 0;

  serial_mag_comp #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .yg    (yg),
    .yl    (yl),
    .ye    (ye)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected flags {gt,lt,eq} from whole-number ordering; latency from the first differing digit.
  function automatic void refModel(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                   output int k, output logic [2:0] flags);
    int  da, db;
    bit  found;
    bit  greater, less;
`ifdef COMP_SIGNED_EN
    greater = ($signed(ta) > $signed(tb));
    less    = ($signed(ta) < $signed(tb));
`else
    greater = (ta > tb);
    less    = (ta < tb);
`endif
    flags = greater ? 3'b100 : (less ? 3'b010 : 3'b001);
    k = N;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      da = int'((ta >> (WIDTH - DIGIT * (i + 1))) & 16'h000F);
      db = int'((tb >> (WIDTH - DIGIT * (i + 1))) & 16'h000F);
      if (!found && da != db) begin
        k = i + 1;
        found = 1'b1;
      end
    end
  endfunction

  task automatic checkAccepted(input string tag);
    checkOutput({tag, "_busy_e0"}, 32'(busy), 32'd1);
    checkOutput({tag, "_done_e0"}, 32'(done), 32'd0);
    checkOutput({tag, "_flags_e0"}, 32'({yg, yl, ye}), 32'd0);
  endtask

  task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb);
    @(negedge clk);
    a = ta;
    b = tb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkAccepted(tag);
  endtask

  // Called #1 after the accepting edge; pokeAt>0 pulses a foreign start on that edge.
  // keepStart leaves start high so the DONE cycle re-accepts.
  task automatic awaitResult(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                             input int pokeAt, input bit keepStart);
    int         k, cyc;
    logic [2:0] flags;
    refModel(ta, tb, k, flags);
    cyc = 0;
    while (done !== 1'b1 && cyc < WAIT_MAX) begin
      if (pokeAt == cyc + 1) begin
        a = 16'hFFFF;
        b = 16'h0000;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!keepStart) start = 1'b0;
      cyc++;
      if (done !== 1'b1) begin
        checkOutput({tag, "_busy_run"}, 32'(busy), 32'd1);
        checkOutput({tag, "_flags_run"}, 32'({yg, yl, ye}), 32'd0);
      end
    end
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(k));
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_busy_done"}, 32'(busy), 32'd0);
    checkOutput({tag, "_flags"}, 32'({yg, yl, ye}), 32'(flags));
    if (!keepStart) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
      checkOutput({tag, "_flags_hold"}, 32'({yg, yl, ye}), 32'(flags));
    end
  endtask

  task automatic runCompare(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb);
    applyStimulus(tag, ta, tb);
    awaitResult(tag, ta, tb, 0, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    int               nib;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outs", 32'({busy, done, yg, yl, ye}), 32'd0);
    rst_n = 1'b1;

    runCompare("equal", 16'h1234, 16'h1234);
    runCompare("msb_sign", 16'h8000, 16'h7FFF);
    runCompare("last_digit", 16'h00F0, 16'h00F1);
    runCompare("first_digit", 16'hFFFF, 16'h0FFF);

    $display("[TB] start during RUN");
    applyStimulus("ignore", 16'h0001, 16'h0002);
    awaitResult("ignore", 16'h0001, 16'h0002, 2, 1'b0);

    $display("[TB] reset mid-run");
    applyStimulus("abort", 16'h1111, 16'h1111);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_outs", 32'({busy, done, yg, yl, ye}), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk);
      #1;
      checkOutput("abort_no_done", 32'(done), 32'd0);
    end
    runCompare("after_abort", 16'hA5A5, 16'hA5A4);

    $display("[TB] back-to-back");
    applyStimulus("chain1", 16'h00F0, 16'h00F1);
    a = 16'h0005;
    b = 16'h0003;
    start = 1'b1;
    awaitResult("chain1", 16'h00F0, 16'h00F1, 0, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkAccepted("chain2");
    awaitResult("chain2", 16'h0005, 16'h0003, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 2))
        0: rb = ra;
        1: begin
          nib = int'($urandom_range(0, N - 1));
          rb = ra ^ (WIDTH'($urandom_range(1, 15)) << (DIGIT * nib));
        end
        default: rb = WIDTH'($urandom);
      endcase
      runCompare("random", ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
